// File: rtl/shift_xfer_ctrl.sv
// shift_xfer_ctrl: parallel-to-serial / serial-to-parallel frame sequencer.
// Shifts a tx word out at DIV clocks per bit while capturing ser_in into rx.
module shift_xfer_ctrl #(
  parameter int WIDTH     = 16,
  parameter int DIV       = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             ser_out,
  input  logic             ser_in,
  output logic             shift_en,
  output logic             frame,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             overrun
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             done;

  assign frame       = (state_q == SHIFT);
  assign start_ready = (state_q == IDLE);
  assign shift_en    = frame && (div_q == DIV_LAST);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign overrun     = overrun_q;

  // Line is forced low outside a frame so an idle link reads as 0.
  assign ser_out = frame &&
                   (LSB_FIRST ? tx_q[0] : tx_q[WIDTH-1]);

  // Next-state: frame sequencing, bit shifting and rx handshake.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    div_d      = div_q;
    bit_d      = bit_q;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          tx_d    = tx_data;
          div_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          div_d   = '0;
          tx_d    = LSB_FIRST ? (tx_q >> 1) : (tx_q << 1);
          rx_sh_d = LSB_FIRST ?
                    {ser_in, rx_sh_q[WIDTH-1:1]} :
                    {rx_sh_q[WIDTH-2:0], ser_in};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            done    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A completion always wins; a pending unconsumed word becomes overrun.
    if (done) begin
      rx_data_d  = rx_sh_d;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ready) overrun_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      div_q      <= '0;
      bit_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
    end
  end

endmodule

// File: doc/shift_xfer_ctrl.md
Name: shift_xfer_ctrl

Overview:
Sequencer for the serial shift datapath. It accepts a parallel word over a valid/ready handshake and shifts it out serially at a programmable bit rate. At the same time it shifts serial input bits into a receive register and presents the received word over a second valid/ready handshake. This block is the controller between the multiplier's parallel operand/result side and its serial-in/serial-out links.

Parameters:
WIDTH, 16, bits per frame (>=2)
DIV, 4, clk cycles per serial bit (>=1)
LSB_FIRST, 0, 0 = shift MSB first, 1 = shift LSB first (applies to both tx and rx)

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
start_valid  in  1  tx_data valid; request to start a frame
start_ready  out  1  high when a frame can be accepted
tx_data  in  WIDTH  parallel word to transmit
ser_out  out  1  serial transmit bit
ser_in  in  1  serial receive bit
shift_en  out  1  one-cycle strobe at each bit sample/shift point
frame  out  1  high while a frame is being shifted
rx_data  out  WIDTH  last completed received word
rx_valid  out  1  rx_data holds an unconsumed word
rx_ready  in  1  consumer accepts rx_data
overrun  out  1  sticky: an unconsumed rx word was overwritten

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. While rst is high at a rising edge, all state returns to reset values.
- Reset values: state=IDLE, start_ready=1, frame=0, ser_out=0, shift_en=0, rx_data=0, rx_valid=0, overrun=0, and all internal counters and shift registers are 0.
- Reset mid-frame: the frame is aborted, no rx_valid pulse is produced, and outputs return to reset values at that edge.
- States are IDLE and SHIFT.
- IDLE:
  - start_ready=1, frame=0, ser_out=0.
  - Accept occurs when start_valid and start_ready are both high on the same edge (cycle T).
  - On accept: tx_data loads into the tx shift register, div_cnt=0, bit_cnt=0, and the state moves to SHIFT.
- SHIFT:
  - start_ready=0 and frame=1 for cycles T+1 through T+WIDTH*DIV inclusive.
  - start_valid is ignored while in SHIFT.
  - ser_out = tx_reg[WIDTH-1] when LSB_FIRST=0, else tx_reg[0]. Each bit is held for exactly DIV cycles.
  - div_cnt counts 0..DIV-1. shift_en=1 in the cycle where div_cnt==DIV-1; when DIV=1, shift_en is high every SHIFT cycle.
  - On the edge that ends a shift_en cycle:
    - the tx register shifts by one position, filling with 0;
    - ser_in is sampled into the rx shift register in the same order as tx, so looping ser_out to ser_in gives rx_data==tx_data;
    - bit_cnt increments.
  - The shift_en edge with bit_cnt==WIDTH-1 is the last bit. On that edge:
    - rx_data is loaded with the complete word;
    - rx_valid is set to 1;
    - the state returns to IDLE.
  - Result: rx_valid and start_ready are both high at cycle T+WIDTH*DIV+1.
- Receive handshake:
  - rx_valid clears on an edge where rx_valid and rx_ready are both high and no new completion occurs on that edge.
  - rx_data stays stable while rx_valid=1 unless a new completion overwrites it.
- Completion while a word is pending:
  - If a completion occurs while rx_valid=1 and rx_ready=0: rx_data is overwritten, rx_valid stays 1, and overrun is set to 1.
  - If a completion coincides with rx_ready=1: the old word counts as consumed, the new word loads, rx_valid stays 1, and overrun is unchanged.
- overrun clears only on rst.
- Back-to-back frames: start_ready does not wait for rx_valid, so a new frame may be accepted in the first IDLE cycle. The minimum frame-to-frame spacing is WIDTH*DIV+1 cycles.
- Counter widths: div_cnt uses clog2(DIV) bits (minimum 1) and bit_cnt uses clog2(WIDTH) bits. Neither counter may wrap inside a frame.

Test Plan:
1. Loopback (ser_out tied to ser_in), DIV=4, LSB_FIRST=0, accept 16'hA5C3 at cycle T:
   - ser_out shows 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, each bit held 4 cycles;
   - frame is high for 64 cycles and shift_en pulses 16 times;
   - rx_data=16'hA5C3 and rx_valid=1 at T+65.
2. LSB_FIRST=1, loopback, tx_data=16'h0001: ser_out is 1 for the first 4 SHIFT cycles and 0 afterwards; rx_data=16'h0001.
3. Open loop with ser_in held at 1, tx_data=16'h1234: rx_data=16'hFFFF. Holding start_valid=1 during SHIFT does not start a second frame; start_ready stays 0 until T+65.
4. Two frames (16'h00FF then 16'hFF00) with rx_ready=0 throughout: after the second completion rx_data=16'hFF00, rx_valid=1, overrun=1. Repeat with rx_ready=1 on the second completion edge: overrun stays 0.
5. Assert rst for 1 cycle at cycle T+20 of a frame: frame=0, ser_out=0, rx_valid=0 and start_ready=1 on the following cycle; no completion occurs. A new frame afterwards completes correctly.
6. DIV=1, start_valid held high with loopback: consecutive accepts are 17 cycles apart, shift_en is high for 16 consecutive cycles per frame, and each rx_data equals its tx_data.
